// File: rtl/pkg_soc_interconnect.sv
// Shared definitions for the SoC interconnect: error-response poison word and
// error-slave FSM state encoding.
package pkg_soc_interconnect;

  localparam logic [31:0] POISON_WORD = 32'hBADACCE5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } err_slave_state_e;

endpackage

// File: rtl/tcdm_err_log.sv
// Error log for the TCDM error slave: saturating grant counter, first-error
// capture, clear handling and optional IRQ pulse (TCDM_ERR_SLAVE_IRQ_EN).
module tcdm_err_log #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 gnt_i,
  input  logic                 clear_i,
  input  logic [31:0]          add_i,
  input  logic                 wen_i,
  output logic                 err_valid_o,
  output logic [31:0]          err_addr_o,
  output logic                 err_wen_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 err_irq_o
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A same-cycle clear wipes the log first, so the granted access becomes the new first error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o   <= '0;
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_wen_o   <= 1'b0;
    end else begin
      if (clear_i) begin
        err_cnt_o   <= '0;
        err_valid_o <= 1'b0;
        err_addr_o  <= '0;
        err_wen_o   <= 1'b0;
      end
      if (gnt_i) begin
        err_cnt_o <= clear_i ? CNT_WIDTH'(1) : sat_inc(err_cnt_o);
        if (clear_i || !err_valid_o) begin
          err_valid_o <= 1'b1;
          err_addr_o  <= add_i;
          err_wen_o   <= wen_i;
        end
      end
    end
  end

`ifdef TCDM_ERR_SLAVE_IRQ_EN
  logic irq_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_p1 <= 1'b0;
    else       irq_p1 <= gnt_i & ~err_valid_o;
  end

  assign err_irq_o = irq_p1;
`else
  assign err_irq_o = 1'b0;
`endif

endmodule

// File: rtl/tcdm_error_slave.sv
// TCDM CFI slave terminating unmapped accesses with an error response and poison data.
// Optional IRQ output enabled by defining TCDM_ERR_SLAVE_IRQ_EN.
module tcdm_error_slave
  import pkg_soc_interconnect::*;
#(
  parameter int CFI_DATA_WIDTH = 32,
  parameter int GNT_DELAY      = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [31:0]               add_i,
  input  logic                      wen_i,
  input  logic [CFI_DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]                be_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [CFI_DATA_WIDTH-1:0] r_rdata_o,
  output logic                      r_opc_o,
  input  logic                      clear_i,
  output logic                      err_valid_o,
  output logic [31:0]               err_addr_o,
  output logic                      err_wen_o,
  output logic [CNT_WIDTH-1:0]      err_cnt_o,
  output logic                      err_irq_o
);

  function automatic logic [CFI_DATA_WIDTH-1:0] poison_fill();
    logic [CFI_DATA_WIDTH-1:0] w;
    for (int i = 0; i < CFI_DATA_WIDTH; i++) w[i] = POISON_WORD[i % 32];
    return w;
  endfunction

  localparam logic [CFI_DATA_WIDTH-1:0] POISON_DW = poison_fill();
  // WAIT is entered after the first req cycle, so it counts down from GNT_DELAY-1.
  localparam logic [3:0] WAIT_LOAD = (GNT_DELAY > 0) ? 4'(GNT_DELAY - 1) : 4'd0;

  err_slave_state_e state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic             gnt;
  logic             unused_inputs;

  assign unused_inputs = ^{wdata_i, be_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    gnt     = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (GNT_DELAY == 0) begin
          gnt     = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (wait_q == 4'd0) begin
          gnt     = 1'b1;
          state_d = ST_RESP;
        end else begin
          wait_d  = wait_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response stage: RESP state is the registered one-cycle response after a grant.
  assign gnt_o     = gnt & ~rst_i;
  assign r_valid_o = (state_q == ST_RESP);
  assign r_opc_o   = r_valid_o;
  assign r_rdata_o = r_valid_o ? POISON_DW : '0;

  tcdm_err_log #(
    .CNT_WIDTH (CNT_WIDTH)
  ) i_log (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gnt_i       (gnt_o),
    .clear_i     (clear_i),
    .add_i       (add_i),
    .wen_i       (wen_i),
    .err_valid_o (err_valid_o),
    .err_addr_o  (err_addr_o),
    .err_wen_o   (err_wen_o),
    .err_cnt_o   (err_cnt_o),
    .err_irq_o   (err_irq_o)
  );

endmodule

// File: tb/tb_tcdm_error_slave.sv
// Directed bench for tcdm_error_slave: three instances cover GNT_DELAY=0,
// GNT_DELAY=3 and a 4-bit saturating counter.
module tb_tcdm_error_slave;

`ifdef TCDM_ERR_SLAVE_IRQ_EN
  localparam int IRQ_EN = 1;
`else
  localparam int IRQ_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        req0, clr0, gnt0, rv0, opc0, ev0, ew0, irq0;
  logic [31:0] rd0, ea0;
  logic [15:0] cnt0;
  logic        req3, clr3, gnt3, rv3, opc3, ev3, ew3, irq3;
  logic [31:0] rd3, ea3;
  logic [15:0] cnt3;
  logic        req4, clr4, gnt4, rv4, opc4, ev4, ew4, irq4;
  logic [31:0] rd4, ea4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tcdm_error_slave #(.CFI_DATA_WIDTH(32), .GNT_DELAY(0), .CNT_WIDTH(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt0), .r_valid_o(rv0), .r_rdata_o(rd0), .r_opc_o(opc0), .clear_i(clr0),
    .err_valid_o(ev0), .err_addr_o(ea0), .err_wen_o(ew0), .err_cnt_o(cnt0), .err_irq_o(irq0));

  tcdm_error_slave #(.CFI_DATA_WIDTH(32), .GNT_DELAY(3), .CNT_WIDTH(16)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt3), .r_valid_o(rv3), .r_rdata_o(rd3), .r_opc_o(opc3), .clear_i(clr3),
    .err_valid_o(ev3), .err_addr_o(ea3), .err_wen_o(ew3), .err_cnt_o(cnt3), .err_irq_o(irq3));

  tcdm_error_slave #(.CFI_DATA_WIDTH(32), .GNT_DELAY(0), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt4), .r_valid_o(rv4), .r_rdata_o(rd4), .r_opc_o(opc4), .clear_i(clr4),
    .err_valid_o(ev4), .err_addr_o(ea4), .err_wen_o(ew4), .err_cnt_o(cnt4), .err_irq_o(irq4));

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b want=0", gnt0); end
    total++; if ({rv0, opc0, ev0, ew0, irq0} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b want=00000", {rv0, opc0, ev0, ew0, irq0}); end
    total++; if (rd0 !== 32'h0 || ea0 !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h want=0/0", rd0, ea0); end
    total++; if (cnt0 !== 16'h0 || cnt3 !== 16'h0 || cnt4 !== 4'h0) begin bad++; $display("FAIL rst_cnt got=%h/%h/%h want=0", cnt0, cnt3, cnt4); end
    @(negedge clk); req0 = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL rst_release_rv got=%0b want=0", rv0); end
  endtask

  task automatic test_single_read();
    @(negedge clk); req0 = 1'b1; add = 32'h1C00_0000; wen = 1'b1; #1;
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%0b want=1", gnt0); end
    total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL rd_rv_early got=%0b want=0", rv0); end
    @(negedge clk); req0 = 1'b0; #1;
    total++; if (rv0 !== 1'b1 || opc0 !== 1'b1) begin bad++; $display("FAIL rd_resp got=%0b%0b want=11", rv0, opc0); end
    total++; if (rd0 !== 32'hBADACCE5) begin bad++; $display("FAIL rd_rdata got=%h want=badacce5", rd0); end
    total++; if (ea0 !== 32'h1C00_0000 || ew0 !== 1'b1 || ev0 !== 1'b1) begin bad++; $display("FAIL rd_log got=%h/%0b/%0b want=1c000000/1/1", ea0, ew0, ev0); end
    total++; if (cnt0 !== 16'd1) begin bad++; $display("FAIL rd_cnt got=%0d want=1", cnt0); end
    total++; if (irq0 !== 1'(IRQ_EN)) begin bad++; $display("FAIL rd_irq got=%0b want=%0d", irq0, IRQ_EN); end
    @(negedge clk); #1;
    total++; if ({rv0, opc0} !== 2'b00 || rd0 !== 32'h0) begin bad++; $display("FAIL rd_idle got=%0b%0b/%h want=00/0", rv0, opc0, rd0); end
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL rd_irq_end got=%0b want=0", irq0); end
  endtask

  task automatic test_back_to_back();
    int n_gnt = 0, n_rv = 0, n_irq = 0;
    @(negedge clk); clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0; #1;
    total++; if (cnt0 !== 16'd0 || ev0 !== 1'b0 || ea0 !== 32'h0) begin bad++; $display("FAIL clr got=%0d/%0b/%h want=0/0/0", cnt0, ev0, ea0); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req0 = 1'b1; add = 32'h2000_0000 + 32'(4 * i); wen = 1'b0; #1;
      if (gnt0 === 1'b1) n_gnt++;
      if (rv0 === 1'b1) n_rv++;
      if (irq0 === 1'b1) n_irq++;
      total++; if (rv0 !== (i > 0)) begin bad++; $display("FAIL b2b_rv[%0d] got=%0b want=%0b", i, rv0, i > 0); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); req0 = 1'b0; #1;
      if (rv0 === 1'b1) n_rv++;
      if (irq0 === 1'b1) n_irq++;
    end
    total++; if (n_gnt != 8) begin bad++; $display("FAIL b2b_gnts got=%0d want=8", n_gnt); end
    total++; if (n_rv != 8) begin bad++; $display("FAIL b2b_rvalids got=%0d want=8", n_rv); end
    total++; if (cnt0 !== 16'd8) begin bad++; $display("FAIL b2b_cnt got=%0d want=8", cnt0); end
    total++; if (ea0 !== 32'h2000_0000 || ew0 !== 1'b0) begin bad++; $display("FAIL b2b_addr got=%h/%0b want=20000000/0", ea0, ew0); end
    total++; if (n_irq != IRQ_EN) begin bad++; $display("FAIL b2b_irq got=%0d want=%0d", n_irq, IRQ_EN); end
  endtask

  task automatic test_gnt_delay();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); req3 = 1'b1; add = 32'h3000_0000; wen = 1'b1; #1;
      total++; if (gnt3 !== (k == 4)) begin bad++; $display("FAIL dly_gnt[%0d] got=%0b want=%0b", k, gnt3, k == 4); end
    end
    @(negedge clk); req3 = 1'b0; #1;
    total++; if (rv3 !== 1'b1 || rd3 !== 32'hBADACCE5) begin bad++; $display("FAIL dly_rv got=%0b/%h want=1/badacce5", rv3, rd3); end
    total++; if (cnt3 !== 16'd1 || ea3 !== 32'h3000_0000) begin bad++; $display("FAIL dly_log got=%0d/%h want=1/30000000", cnt3, ea3); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); req3 = (k <= 2); add = 32'h3100_0000; #1;
      total++; if (gnt3 !== 1'b0 || (k > 1 && rv3 !== 1'b0)) begin bad++; $display("FAIL drop[%0d] got=%0b/%0b want=0/0", k, gnt3, rv3); end
    end
    total++; if (cnt3 !== 16'd1 || ea3 !== 32'h3000_0000) begin bad++; $display("FAIL drop_log got=%0d/%h want=1/30000000", cnt3, ea3); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); req4 = 1'b1; add = 32'h4000_0000 + 32'(i); wen = 1'b0;
    end
    @(negedge clk); req4 = 1'b0; #1;
    total++; if (cnt4 !== 4'hF) begin bad++; $display("FAIL sat_cnt got=%h want=f", cnt4); end
    total++; if (ea4 !== 32'h4000_0000) begin bad++; $display("FAIL sat_addr got=%h want=40000000", ea4); end
    @(negedge clk); clr4 = 1'b1; req4 = 1'b1; add = 32'h4444_0000; wen = 1'b1; #1;
    total++; if (gnt4 !== 1'b1) begin bad++; $display("FAIL clrgnt_gnt got=%0b want=1", gnt4); end
    @(negedge clk); clr4 = 1'b0; req4 = 1'b0; #1;
    total++; if (cnt4 !== 4'h1 || ev4 !== 1'b1) begin bad++; $display("FAIL clrgnt_cnt got=%h/%0b want=1/1", cnt4, ev4); end
    total++; if (ea4 !== 32'h4444_0000 || ew4 !== 1'b1) begin bad++; $display("FAIL clrgnt_addr got=%h/%0b want=44440000/1", ea4, ew4); end
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk); req0 = 1'b1; add = 32'h5000_0000; wen = 1'b1;
    @(negedge clk); req0 = 1'b0; #1;
    total++; if (rv0 !== 1'b1) begin bad++; $display("FAIL rr_rv_pre got=%0b want=1", rv0); end
    #1 rst = 1'b1; #1;
    total++; if (rv0 !== 1'b0 || opc0 !== 1'b0 || rd0 !== 32'h0) begin bad++; $display("FAIL rr_resp got=%0b%0b/%h want=00/0", rv0, opc0, rd0); end
    total++; if (cnt0 !== 16'd0 || ev0 !== 1'b0 || ea0 !== 32'h0 || ew0 !== 1'b0) begin bad++; $display("FAIL rr_log got=%0d/%0b/%h/%0b want=0", cnt0, ev0, ea0, ew0); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++; if (rv0 !== 1'b0 || irq0 !== 1'b0) begin bad++; $display("FAIL rr_after[%0d] got=%0b/%0b want=0/0", k, rv0, irq0); end
    end
  endtask

  initial begin
    rst = 1'b1; add = '0; wen = 1'b0; wdata = 32'hDEAD_BEEF; be = 4'hF;
    req0 = 1'b0; clr0 = 1'b0; req3 = 1'b0; clr3 = 1'b0; req4 = 1'b0; clr4 = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_gnt_delay();
    test_saturate();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
